// File: rtl/stage_operator_writeback.sv
// ---------------------------------------------------------------------------
// stage_operator_writeback
//
// Final stage of the operator pipeline. Every valid beat is forwarded, one
// cycle later, to the modulator's operator-writeback port (gated to zero while
// the voice is off). Carrier operators are accumulated across one full sweep
// of all voice-operator IDs, and each completed sweep produces one saturated
// audio sample. Sweep order is tracked; an unexpected ID discards the partial
// sweep and either restarts (ID 0) or falls back to waiting for ID 0.
//
// Ports
//   i_Clock                  system clock
//   i_Reset                  synchronous, active-high reset
//   i_Valid                  input fields valid this cycle
//   i_VoiceOperator          {voice, operator} ID of the incoming result
//   i_NoteOn                 voice gate for this result
//   i_AlgorithmWord          [7] IsCarrier, [10:8] carrier attenuation shift
//   i_OperatorOutput         finished signed operator output
//   o_OperatorWritebackID    writeback address to the modulator
//   o_OperatorWritebackValue writeback data to the modulator
//   o_Sample                 mixed, saturated sample (holds between pulses)
//   o_SampleValid            one-cycle pulse when o_Sample updates
//   o_SeqError               one-cycle pulse on an out-of-order ID
// ---------------------------------------------------------------------------
module stage_operator_writeback #(
    parameter int NUM_VOICES    = 32,
    parameter int NUM_OPERATORS = 8,
    parameter int ACC_WIDTH     = 24,
    localparam int ID_W         = $clog2(NUM_VOICES * NUM_OPERATORS)
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Valid,
    input  logic [ID_W-1:0]        i_VoiceOperator,
    input  logic                   i_NoteOn,
    input  logic [10:0]            i_AlgorithmWord,
    input  logic signed [15:0]     i_OperatorOutput,
    output logic [ID_W-1:0]        o_OperatorWritebackID,
    output logic signed [15:0]     o_OperatorWritebackValue,
    output logic signed [15:0]     o_Sample,
    output logic                   o_SampleValid,
    output logic                   o_SeqError
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_VOICES * NUM_OPERATORS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(32768);

    typedef enum logic {SYNC, RUN} state_t;

    state_t                      state, stateNext;
    logic signed [ACC_WIDTH-1:0] acc, accNext;
    logic [ID_W-1:0]             expected, expectedNext;
    logic signed [15:0]          sampleNext;
    logic                        sampleValidNext;
    logic                        seqErrorNext;

    logic signed [ACC_WIDTH-1:0] carrier_p0;
    logic signed [ACC_WIDTH-1:0] accSum_p0;
    logic                        idMatch_p0;
    logic                        idZero_p0;
    logic                        idLast_p0;
    logic                        unusedAlgBits;

    // Only the carrier flag and shift are consumed here.
    assign unusedAlgBits = ^i_AlgorithmWord[6:0];

    function automatic logic signed [15:0] sat16(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)      return 16'sh7FFF;
        else if (v < SAT_MIN) return -16'sh8000;
        else                  return v[15:0];
    endfunction

    // Input stage: carrier contribution and decoded sweep position.
    always_comb begin
        carrier_p0 = '0;
        if (i_NoteOn && i_AlgorithmWord[7])
            carrier_p0 = ACC_WIDTH'(i_OperatorOutput) >>> i_AlgorithmWord[10:8];
    end

    assign accSum_p0  = acc + carrier_p0;
    assign idMatch_p0 = (i_VoiceOperator == expected);
    assign idZero_p0  = (i_VoiceOperator == '0);
    assign idLast_p0  = (i_VoiceOperator == LAST_ID);

    // State register and registered outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state                    <= SYNC;
            acc                      <= '0;
            expected                 <= '0;
            o_Sample                 <= '0;
            o_SampleValid            <= 1'b0;
            o_SeqError               <= 1'b0;
            o_OperatorWritebackID    <= '0;
            o_OperatorWritebackValue <= '0;
        end else begin
            state         <= stateNext;
            acc           <= accNext;
            expected      <= expectedNext;
            o_Sample      <= sampleNext;
            o_SampleValid <= sampleValidNext;
            o_SeqError    <= seqErrorNext;
            // Writeback runs regardless of sweep state; it holds when idle.
            if (i_Valid) begin
                o_OperatorWritebackID    <= i_VoiceOperator;
                o_OperatorWritebackValue <= i_NoteOn ? i_OperatorOutput : 16'sd0;
            end
        end
    end

    // Next-state logic: sweep tracking and accumulation.
    always_comb begin
        stateNext    = state;
        accNext      = acc;
        expectedNext = expected;
        case (state)
            SYNC: begin
                accNext      = '0;
                expectedNext = '0;
                if (i_Valid && idZero_p0) begin
                    accNext      = carrier_p0;
                    expectedNext = ID_W'(1);
                    stateNext    = RUN;
                end
            end
            RUN: begin
                if (i_Valid) begin
                    if (idMatch_p0 && idLast_p0) begin
                        accNext      = '0;
                        expectedNext = '0;
                    end else if (idMatch_p0) begin
                        accNext      = accSum_p0;
                        expectedNext = expected + ID_W'(1);
                    end else if (idZero_p0) begin
                        // Out of order but a fresh sweep start: restart in place.
                        accNext      = carrier_p0;
                        expectedNext = ID_W'(1);
                    end else begin
                        accNext      = '0;
                        expectedNext = '0;
                        stateNext    = SYNC;
                    end
                end
            end
            default: begin
                stateNext    = SYNC;
                accNext      = '0;
                expectedNext = '0;
            end
        endcase
    end

    // Output logic: sample and error pulses, mutually exclusive by construction.
    always_comb begin
        sampleNext      = o_Sample;
        sampleValidNext = 1'b0;
        seqErrorNext    = 1'b0;
        if (state == RUN && i_Valid) begin
            if (idMatch_p0 && idLast_p0) begin
                sampleNext      = sat16(accSum_p0);
                sampleValidNext = 1'b1;
            end else if (!idMatch_p0) begin
                seqErrorNext = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stage_operator_writeback.sv
module tb_stage_operator_writeback;

    localparam int NV    = 32;
    localparam int NO    = 8;
    localparam int NIDS  = NV * NO;
    localparam int ID_W  = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 vld = 1'b0;
    logic [ID_W-1:0]      vo = '0;
    logic                 noteOn = 1'b0;
    logic [10:0]          word = '0;
    logic signed [15:0]   opOut = '0;
    logic [ID_W-1:0]      wbId;
    logic signed [15:0]   wbVal;
    logic signed [15:0]   sample;
    logic                 sampleValid;
    logic                 seqError;

    stage_operator_writeback #(
        .NUM_VOICES(NV), .NUM_OPERATORS(NO), .ACC_WIDTH(24)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Valid(vld),
        .i_VoiceOperator(vo),
        .i_NoteOn(noteOn),
        .i_AlgorithmWord(word),
        .i_OperatorOutput(opOut),
        .o_OperatorWritebackID(wbId),
        .o_OperatorWritebackValue(wbVal),
        .o_Sample(sample),
        .o_SampleValid(sampleValid),
        .o_SeqError(seqError)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct {
        bit isErr;
        int val;
    } ev_t;
    ev_t evQ[$];

    typedef struct {
        int id;
        int val;
    } wb_t;
    wb_t wbQ[$];

    // ---------------- behavioural reference model ----------------
    // A sweep is a run of IDs 0..NIDS-1 in order; its carriers sum as plain
    // integers and the total is clamped to 16 bits.
    bit     mInSweep = 0;
    int     mNext    = 0;
    longint mSum     = 0;

    function automatic int clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic modelBeat(input int id, input bit on, input logic [10:0] w, input int v);
        longint c;
        ev_t e;
        wb_t b;
        b.id  = id;
        b.val = on ? v : 0;
        wbQ.push_back(b);
        c = (on && w[7]) ? (longint'(v) / (64'sd1 << w[10:8])) : 0;
        // Integer division truncates toward zero; correct to floor for negatives.
        if (on && w[7] && v < 0 && (longint'(v) % (64'sd1 << w[10:8])) != 0) c = c - 1;
        if (!mInSweep) begin
            if (id == 0) begin
                mInSweep = 1; mSum = c; mNext = 1;
            end
        end else if (id == mNext) begin
            if (id == NIDS - 1) begin
                e.isErr = 0; e.val = clamp16(mSum + c); evQ.push_back(e);
                mSum = 0; mNext = 0;
            end else begin
                mSum += c; mNext++;
            end
        end else begin
            e.isErr = 1; e.val = 0; evQ.push_back(e);
            if (id == 0) begin
                mSum = c; mNext = 1;
            end else begin
                mInSweep = 0; mSum = 0; mNext = 0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic idle();
        @(posedge clk); #1;
        vld = 1'b0;
        vo = ID_W'($urandom); opOut = 16'($urandom); noteOn = 1'($urandom); word = 11'($urandom);
    endtask

    task automatic beat(input int id, input bit on, input logic [10:0] w, input int v);
        @(posedge clk); #1;
        vld = 1'b1; vo = ID_W'(id); noteOn = on; word = w; opOut = 16'(v);
        modelBeat(id, on, w, v);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1; vld = 1'b0;
        mInSweep = 0; mSum = 0; mNext = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // kind: 0 op0 carrier 100; 1 +30000; 2 -30000; 3 +30000 shift 3;
    //       4 like 0 but voice 5 gated off with 1234; 5 fully random
    task automatic genBeat(input int kind, input int id, output bit on,
                           output logic [10:0] w, output int v);
        int voice, op;
        voice = id / NO;
        op    = id % NO;
        on = 1'b1;
        w  = 11'($urandom) & ~11'h080;
        v  = int'($signed(16'($urandom)));
        if (kind == 5) begin
            on = 1'($urandom);
            w  = 11'($urandom);
        end else if (op == 0) begin
            w = {3'd0, 8'h80};
            case (kind)
                1: v = 30000;
                2: v = -30000;
                3: begin v = 30000; w = {3'd3, 8'h80}; end
                default: v = 100;
            endcase
        end
        if (kind == 4 && voice == 5) begin
            on = 1'b0; v = 1234;
        end
    endtask

    task automatic sweep(input int kind, input int firstId, input int lastId, input int gapPct);
        bit on;
        logic [10:0] w;
        int v;
        for (int id = firstId; id <= lastId; id++) begin
            while (gapPct > 0 && $urandom_range(99) < gapPct) idle();
            genBeat(kind, id, on, w, v);
            beat(id, on, w, v);
        end
    endtask

    // ---------------- monitor ----------------
    bit   armed = 0;
    logic vSeen = 1'b0;
    logic rSeen = 1'b0;
    int   curId = 0, curVal = 0, curSample = 0;

    always @(posedge clk) begin
        vSeen <= vld;
        rSeen <= rst;
    end

    always @(negedge clk) begin
        if (armed) begin
            if (rSeen) begin
                curId = 0; curVal = 0; curSample = 0;
            end else if (vSeen) begin
                if (wbQ.size() == 0) chk("wb queue underflow", 1, 0);
                else begin
                    curId  = wbQ[0].id;
                    curVal = wbQ[0].val;
                    void'(wbQ.pop_front());
                end
            end
            chk("pulse exclusive", longint'(sampleValid && seqError), 0);
            if (sampleValid || seqError) begin
                if (evQ.size() == 0) begin
                    chk("unexpected pulse sv", longint'(sampleValid), 0);
                    chk("unexpected pulse err", longint'(seqError), 0);
                end else begin
                    chk("pulse kind err", longint'(seqError), longint'(evQ[0].isErr));
                    if (!evQ[0].isErr) curSample = evQ[0].val;
                    void'(evQ.pop_front());
                end
            end
            chk("wb id", longint'(wbId), curId);
            chk("wb value", longint'($signed(wbVal)), curVal);
            chk("sample", longint'($signed(sample)), curSample);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        armed = 1;
        rst = 1'b0;

        sweep(0, 0, NIDS - 1, 0);        // 32 x 100 = 3200
        sweep(1, 0, NIDS - 1, 0);        // saturates high
        sweep(2, 0, NIDS - 1, 0);        // saturates low
        sweep(3, 0, NIDS - 1, 0);        // 32 x 3750 still saturates
        sweep(4, 0, NIDS - 1, 0);        // voice 5 gated off

        doReset();
        sweep(0, 17, NIDS - 1, 0);       // ignored until ID 0
        sweep(0, 0, NIDS - 1, 0);

        sweep(5, 0, 99, 0);              // jump 99 -> 120: error, back to SYNC
        sweep(5, 120, NIDS - 1, 0);
        sweep(5, 0, 99, 0);              // jump 99 -> 0: error, restart
        sweep(0, 0, NIDS - 1, 0);

        sweep(0, 0, NIDS - 1, 50);       // gaps, same 3200 result
        sweep(5, 0, NIDS - 1, 50);

        sweep(5, 0, 127, 0);             // reset mid-sweep
        doReset();
        idle();
        sweep(5, 0, NIDS - 1, 0);
        sweep(3, 0, NIDS - 1, 30);

        repeat (4) idle();
        chk("events drained", evQ.size(), 0);
        chk("writebacks drained", wbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
